// File: rtl/mouse_ps2_packet_rx.sv
// ---------------------------------------------------------------------------
// mouse_ps2_packet_rx
//
// PS/2 mouse receiver that runs entirely in the system clock domain. The raw
// PS/2 clock and data pins are synchronised, the PS/2 clock is de-glitched by
// a run-length filter, and the falling edges of the filtered clock drive an
// 11-bit frame deserialiser (start, 8 data LSB-first, odd parity, stop).
// Accepted bytes are assembled into 3-byte (standard) or 4-byte (wheel)
// movement packets, and the decoded fields are published with a one-cycle
// pkt_valid strobe. A watchdog abandons partial frames/packets when the
// mouse stops clocking.
//
// Parameters
//   SYNC_STAGES     flops in each pin synchroniser (>= 2)
//   FILTER_LEN      consecutive differing samples before the filtered clock flips
//   TIMEOUT_CYCLES  busy cycles without a PS/2 clock fall before abandoning
//   PACKET_BYTES    3 (standard) or 4 (wheel)
//
// Ports
//   clock_100Mhz  in   system clock
//   reset         in   synchronous, active-high reset
//   mouse_clk     in   raw PS/2 clock pin (asynchronous)
//   mouse_data    in   raw PS/2 data pin (asynchronous)
//   pkt_valid     out  one-cycle strobe: a new packet is on the outputs
//   buttons       out  {middle, right, left}
//   dx, dy        out  signed 9-bit deltas, saturated on overflow
//   dz            out  signed 4-bit wheel delta (0 for 3-byte packets)
//   x_ovf, y_ovf  out  overflow flags of the last packet
//   frame_err     out  one-cycle strobe: parity, stop or sync-bit error
//   timeout_err   out  one-cycle strobe: partial frame/packet abandoned
// ---------------------------------------------------------------------------
module mouse_ps2_packet_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int PACKET_BYTES   = 3
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic              mouse_clk,
    input  logic              mouse_data,
    output logic              pkt_valid,
    output logic [2:0]        buttons,
    output logic signed [8:0] dx,
    output logic signed [8:0] dy,
    output logic signed [3:0] dz,
    output logic              x_ovf,
    output logic              y_ovf,
    output logic              frame_err,
    output logic              timeout_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_TERM = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_TERM   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    LAST_IDX  = 2'(PACKET_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Overflowed deltas clamp to the extreme of the direction given by the sign.
    function automatic logic signed [8:0] sat_delta(input logic       sign_bit,
                                                    input logic       ovf,
                                                    input logic [7:0] mag);
        if (ovf) begin
            return sign_bit ? 9'sh100 : 9'sh0FF;
        end
        return $signed({sign_bit, mag});
    endfunction

    // Synchroniser and clock filter
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q;
    logic [FW-1:0]          filt_cnt_q, filt_cnt_d;

    logic clk_s;
    logic ps2_data;
    logic fall;

    // Frame FSM and packet assembly
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    byte0_q, byte0_d;
    logic [7:0]    byte1_q, byte1_d;
    logic [7:0]    byte2_q, byte2_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    // FSM decode strobes
    logic byte_ok;
    logic stop_err;
    logic sync_err;
    logic store;
    logic last_byte;
    logic busy;
    logic timeout_hit;

    // Output registers
    logic              pkt_valid_q, pkt_valid_d;
    logic [2:0]        buttons_q, buttons_d;
    logic signed [8:0] dx_q, dx_d;
    logic signed [8:0] dy_q, dy_d;
    logic signed [3:0] dz_q, dz_d;
    logic              x_ovf_q, x_ovf_d;
    logic              y_ovf_q, y_ovf_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_err_q, timeout_err_d;

    logic [7:0] pb0, pb1, pb2;

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data = data_sync_q[SYNC_STAGES-1];
    // Both operands are registered, so the fall strobe is glitch-free and
    // lasts exactly one cycle.
    assign fall     = filt_dly_q & ~filt_q;

    // ---------------- synchroniser / filter ----------------
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_s == filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_TERM) begin
            filt_d     = ~filt_q;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            // Preset to the idle-bus level so reset never manufactures a fall.
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= 1'b1;
            filt_dly_q  <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], mouse_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], mouse_data};
            filt_q      <= filt_d;
            filt_dly_q  <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // ---------------- frame FSM: state register ----------------
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- frame FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE:   if (!ps2_data) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- frame FSM: outputs / decode ----------------
    always_comb begin
        byte_ok   = fall && (state_q == ST_STOP) && ps2_data && (^{shift_q, par_q});
        stop_err  = fall && (state_q == ST_STOP) && !(ps2_data && (^{shift_q, par_q}));
        // The first byte of every packet carries a constant 1 in bit 3; a
        // byte without it cannot be a packet start, so resynchronise.
        sync_err  = byte_ok && (idx_q == 2'd0) && !shift_q[3];
        store     = byte_ok && !sync_err;
        last_byte = store && (idx_q == LAST_IDX);
        busy      = (state_q != ST_IDLE) || (idx_q != 2'd0);
        // A fall in the terminal cycle is real activity and wins.
        timeout_hit = !fall && busy && (idle_cnt_q == TO_TERM);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        idx_d      = idx_q;
        byte0_d    = byte0_q;
        byte1_d    = byte1_q;
        byte2_d    = byte2_q;
        idle_cnt_d = idle_cnt_q;

        pkt_valid_d   = 1'b0;
        frame_err_d   = stop_err | sync_err;
        timeout_err_d = timeout_hit;
        buttons_d     = buttons_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        dz_d          = dz_q;
        x_ovf_d       = x_ovf_q;
        y_ovf_d       = y_ovf_q;

        pb0 = byte0_q;
        pb1 = byte1_q;
        pb2 = (PACKET_BYTES == 3) ? shift_q : byte2_q;

        if (fall) begin
            idle_cnt_d = '0;
        end else if (busy && !timeout_hit) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = '0;
        end

        if (fall) begin
            unique case (state_q)
                ST_IDLE:   bit_cnt_d = 3'd0;
                ST_DATA: begin
                    shift_d   = {ps2_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                ST_PARITY: par_d = ps2_data;
                default:   ;
            endcase
        end

        if (timeout_hit || stop_err) begin
            idx_d = 2'd0;
        end else if (store) begin
            unique case (idx_q)
                2'd0:    byte0_d = shift_q;
                2'd1:    byte1_d = shift_q;
                default: byte2_d = shift_q;
            endcase
            idx_d = last_byte ? 2'd0 : idx_q + 2'd1;
        end

        if (last_byte) begin
            pkt_valid_d = 1'b1;
            buttons_d   = pb0[2:0];
            x_ovf_d     = pb0[6];
            y_ovf_d     = pb0[7];
            dx_d        = sat_delta(pb0[4], pb0[6], pb1);
            dy_d        = sat_delta(pb0[5], pb0[7], pb2);
            dz_d        = (PACKET_BYTES == 4) ? $signed(shift_q[3:0]) : 4'sd0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clock_100Mhz) begin
        // Frame payload registers are always rewritten before use.
        bit_cnt_q <= bit_cnt_d;
        shift_q   <= shift_d;
        par_q     <= par_d;
        byte0_q   <= byte0_d;
        byte1_q   <= byte1_d;
        byte2_q   <= byte2_d;
        if (reset) begin
            idx_q         <= 2'd0;
            idle_cnt_q    <= '0;
            pkt_valid_q   <= 1'b0;
            buttons_q     <= 3'd0;
            dx_q          <= '0;
            dy_q          <= '0;
            dz_q          <= '0;
            x_ovf_q       <= 1'b0;
            y_ovf_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            idle_cnt_q    <= idle_cnt_d;
            pkt_valid_q   <= pkt_valid_d;
            buttons_q     <= buttons_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            dz_q          <= dz_d;
            x_ovf_q       <= x_ovf_d;
            y_ovf_q       <= y_ovf_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pkt_valid   = pkt_valid_q;
    assign buttons     = buttons_q;
    assign dx          = dx_q;
    assign dy          = dy_q;
    assign dz          = dz_q;
    assign x_ovf       = x_ovf_q;
    assign y_ovf       = y_ovf_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

endmodule
